// File: rtl/mii_tx_arbiter_if.sv
// Bundle between the two MAC-side frame sources, the arbiter and the
// SGMII bridge's MII TX inputs.
interface mii_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic [3:0] req0_txd;
  logic [3:0] req1_txd;
  logic       req0_tx_en;
  logic       req1_tx_en;
  logic       req0_tx_er;
  logic       req1_tx_er;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;
  logic       jabber;
  logic       busy;

  modport master (
    output req0, req1, req0_txd, req1_txd, req0_tx_en, req1_tx_en,
           req0_tx_er, req1_tx_er,
    input  gnt0, gnt1, mii_txd, mii_tx_en, mii_tx_er, jabber, busy
  );

  modport slave (
    input  req0, req1, req0_txd, req1_txd, req0_tx_en, req1_tx_en,
           req0_tx_er, req1_tx_er,
    output gnt0, gnt1, mii_txd, mii_tx_en, mii_tx_er, jabber, busy
  );
endinterface

// File: rtl/mii_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one MII TX port between two
// sources, with inter-frame gap, grant-to-start timeout and jabber abort.
module mii_tx_arbiter #(
  parameter int unsigned IFG_NIBBLES       = 24,
  parameter int unsigned START_TIMEOUT     = 16,
  parameter int unsigned MAX_FRAME_NIBBLES = 3044
) (
  input  logic            mii_txclk,
  input  logic            rst_l,
  mii_tx_arbiter_if.slave bus
);

  localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] FRAME_LAST = 16'(MAX_FRAME_NIBBLES - 1);
  localparam logic [15:0] IFG_LAST   = 16'(IFG_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, ACTIVE, IFG} state_t;

  state_t      state, state_nxt;
  logic [15:0] count, count_nxt;
  logic        gnt0_q, gnt1_q, gnt0_nxt, gnt1_nxt;
  logic        last_served, last_served_nxt;
  logic        pass, jabber_nxt;
  logic        sel_req, sel_en, sel_er;
  logic [3:0]  sel_txd;
  logic [3:0]  txd_q;
  logic        tx_en_q, tx_er_q, jabber_q, busy_q;

  // Only the granted source is ever looked at; gnt1 picks the mux leg.
  assign sel_req = gnt1_q ? bus.req1       : bus.req0;
  assign sel_en  = gnt1_q ? bus.req1_tx_en : bus.req0_tx_en;
  assign sel_er  = gnt1_q ? bus.req1_tx_er : bus.req0_tx_er;
  assign sel_txd = gnt1_q ? bus.req1_txd   : bus.req0_txd;

  always_comb begin
    state_nxt       = state;
    gnt0_nxt        = gnt0_q;
    gnt1_nxt        = gnt1_q;
    last_served_nxt = last_served;
    pass            = 1'b0;
    jabber_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = GRANT_WAIT;
          if (bus.req0 && (!bus.req1 || last_served)) begin
            gnt0_nxt        = 1'b1;
            last_served_nxt = 1'b0;
          end else begin
            gnt1_nxt        = 1'b1;
            last_served_nxt = 1'b1;
          end
        end
      end
      GRANT_WAIT: begin
        if (sel_en) begin
          state_nxt = ACTIVE;
          pass      = 1'b1;
        end else if (!sel_req || count == START_LAST) begin
          state_nxt = IDLE;
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
        end else begin
          pass = 1'b1;
        end
      end
      ACTIVE: begin
        if (!sel_en) begin
          state_nxt = IFG;
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
        end else if (count == FRAME_LAST) begin
          state_nxt  = IFG;
          gnt0_nxt   = 1'b0;
          gnt1_nxt   = 1'b0;
          jabber_nxt = 1'b1;
        end else begin
          pass = 1'b1;
        end
      end
      IFG: begin
        if (count == IFG_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts from zero on every state entry and idles at zero.
  assign count_nxt = (state_nxt != state || state == IDLE) ? '0 : count + 16'd1;

  always_ff @(posedge mii_txclk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      count       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      last_served <= 1'b1;
      txd_q       <= '0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      jabber_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      gnt0_q      <= gnt0_nxt;
      gnt1_q      <= gnt1_nxt;
      last_served <= last_served_nxt;
      txd_q       <= pass ? sel_txd : '0;
      tx_en_q     <= pass & sel_en;
      tx_er_q     <= pass & sel_er;
      jabber_q    <= jabber_nxt;
      busy_q      <= (state_nxt != IDLE);
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.mii_txd   = txd_q;
  assign bus.mii_tx_en = tx_en_q;
  assign bus.mii_tx_er = tx_er_q;
  assign bus.jabber    = jabber_q;
  assign bus.busy      = busy_q;

endmodule
